sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares the single 8-bit-wide tank bitmap ROM between up to 4 sprite renderers (tank controllers).
- Each requester presents an 8-bit address: bitmap_num[2:0] concatenated with row/half[4:0].
- Round-robin arbitration issues at most one ROM read per clock, with registered grant and registered returned data.
- Sits between the tank controllers' sprite_addr/sprite_bits ports and tank_bitmap, replacing direct wiring once a second tank is added.

Parameters:
- NUM_REQ, 2, number of requesters (legal 1..4).
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width.

Ports:
- clk  input  1  pixel clock (25 MHz domain).
- reset  input  1  asynchronous, active-high reset.
- frame_sync  input  1  single-cycle pulse at frame start (vstart/vsync edge, synchronised to clk).
- req  input  NUM_REQ  per-requester read request; level, held until granted.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  output  NUM_REQ  one-hot grant, registered.
- rom_addr  output  ADDR_W  address to tank_bitmap, registered.
- rom_bits  input  DATA_W  combinational ROM data for rom_addr.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  NUM_REQ  one-hot; rd_data belongs to requester i.
- stall_count  output  16  contention counter (see Optional Feature).

Behaviour:
- Reset (async) values: gnt=0, rom_addr=0, rd_data=0, rd_valid=0, stall_count=0, priority pointer ptr=0.
- Eligible vector, each cycle: elig = req & ~gnt. This masks the requester granted in the current cycle, whose req is stale.
- Winner selection: the first set bit of elig scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
- If elig != 0 at edge T (i.e. registered at end of cycle T):
  - gnt <= onehot(winner)
  - rom_addr <= req_addr[winner]
  - ptr <= (winner+1) mod NUM_REQ
- If elig == 0: gnt <= 0; rom_addr holds its value; ptr holds its value.
- Data return:
  - rd_data <= rom_bits and rd_valid <= gnt, every cycle.
  - Latency is therefore: request visible at cycle T -> gnt high during T+1 -> rd_valid/rd_data during T+2.
- Requester handshake:
  - On seeing gnt[i]=1, requester i may drop req or change req_addr in the same cycle.
  - Requester i is not re-eligible until the cycle after gnt[i] falls, so its minimum re-issue period is 2 cycles.
  - Different requesters can be granted on back-to-back cycles.
- Fairness: a held request is granted within NUM_REQ cycles of becoming eligible. With NUM_REQ=2 and both requesting continuously, grants alternate 0,1,0,1.
- req dropped before grant: the request is withdrawn with no grant and no error.
- frame_sync:
  - Sets ptr <= 0, overriding the winner-based update in the same cycle.
  - Arbitration in that cycle still uses the old ptr.
  - In-flight gnt/rd_valid complete normally.
- NUM_REQ=1: gnt[0] toggles 1,0,1,... while req[0] is held; no contention possible.
- Reset mid-transaction: all outputs clear immediately; a pending read is lost and the requester must re-request.

Optional Feature:
- Macro: SPRITE_ROM_ARB_STATS_EN.
- Defined:
  - stall_count increments by 1 on each cycle where popcount(elig) >= 2, i.e. at least one eligible requester loses.
  - It saturates at 16'hFFFF.
  - It clears to 0 on frame_sync; frame_sync wins over an increment in the same cycle.
- Undefined: stall_count is driven constant 0 and no counter logic is synthesised. The port is always present.

Test Plan:
- Single request: NUM_REQ=2, req=2'b01, addr0=8'h23, rom returns 8'hA5 for 8'h23 -> gnt=01 at T+1, rom_addr=8'h23 at T+1, rd_valid=01 and rd_data=8'hA5 at T+2.
- Contention: req=2'b11 continuously, addr0=8'h00, addr1=8'h41 -> gnt sequence 01,10,01,10, rom_addr alternates 00,41; with STATS_EN, stall_count increments on every cycle where both are eligible.
- Pointer reset: after a grant to requester 0 (ptr=1), pulse frame_sync with req=2'b11 next cycle -> next grant goes to requester 1, the following one to requester 0; stall_count reads 0 after frame_sync.
- Withdrawn request: req=2'b10 for one cycle while requester 0 is being granted, then req drops -> no gnt[1] is ever asserted, rd_valid[1] stays 0.
- Async reset mid-flight: assert reset while gnt=10 -> gnt, rd_valid, rom_addr and stall_count read 0 immediately without waiting for a clock edge; after release with req=2'b11, the first grant goes to requester 0.
- Saturation (STATS_EN): force 70000 contention cycles with no frame_sync -> stall_count = 16'hFFFF and holds; without the macro, stall_count stays 0 throughout.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares the single tank bitmap ROM between up to four sprite renderers.
// Each cycle at most one requester is granted. The grant, the ROM address
// and the returned data are all registered, so a request seen in cycle T
// gets gnt during T+1 and rd_valid/rd_data during T+2. Arbitration is
// round-robin from a priority pointer that frame_sync resets to 0.
//
// Parameters:
//   NUM_REQ  number of requesters (1..4)
//   ADDR_W   ROM address width
//   DATA_W   ROM data width
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   frame_sync   one-cycle pulse at frame start; resets the priority pointer
//   req          per-requester level request, held until granted
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt          one-hot registered grant
//   rom_addr     registered address to the bitmap ROM
//   rom_bits     combinational ROM data for rom_addr
//   rd_data      registered read data
//   rd_valid     one-hot owner of rd_data
//   stall_count  contention counter (constant 0 unless stats are enabled)
//
// Build option:
//   SPRITE_ROM_ARB_STATS_EN  when defined, stall_count counts cycles in which
//                            two or more requesters are eligible. It saturates
//                            at 16'hFFFF and clears on frame_sync.
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_sync,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_bits,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [15:0]               stall_count
);

    // Two bits cover every legal requester count, including NUM_REQ=1.
    localparam int PTR_W = 2;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ADDR_W-1:0]  win_addr;
    int                 best_dist;

    // The requester holding gnt this cycle still shows its old req, so it
    // is masked out; this gives every requester a 2-cycle re-issue period.
    assign elig = req & ~gnt;

    // Round-robin pick: among eligible requesters, choose the one closest
    // to the pointer walking upwards with wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i] && (((i - int'(ptr) + NUM_REQ) % NUM_REQ) < best_dist)) begin
                best_dist = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
    end

    // Decode the winner into a one-hot grant and select its address.
    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_found && (win_idx == PTR_W'(i))) begin
                win_onehot[i] = 1'b1;
                win_addr      = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pointer moves past the winner; frame_sync forces it back to 0 and
    // takes precedence, although this cycle's pick used the old pointer.
    always_comb begin
        ptr_next = ptr;
        if (win_found) begin
            ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        if (frame_sync) begin
            ptr_next = '0;
        end
    end

    // Grant, address and data pipeline. rom_addr is held when nobody wins
    // so the ROM input stays quiet between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            rom_addr <= '0;
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            gnt      <= win_onehot;
            ptr      <= ptr_next;
            rd_data  <= rom_bits;
            rd_valid <= gnt;
            if (win_found) begin
                rom_addr <= win_addr;
            end
        end
    end

`ifdef SPRITE_ROM_ARB_STATS_EN
    int          elig_cnt;
    logic        contention;
    logic [15:0] stall_q;

    // Contention means at least one eligible requester lost this cycle.
    always_comb begin
        elig_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_cnt = elig_cnt + {31'b0, elig[i]};
        end
        contention = (elig_cnt >= 2);
    end

    // Saturating counter, cleared at each frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (frame_sync) begin
            stall_q <= '0;
        end else if (contention && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Directed bench for sprite_rom_arbiter. A two-requester instance walks
// through single reads, contention, pointer reset, withdrawn requests and
// asynchronous reset; a four-requester instance covers 4-way rotation and
// stall counter saturation. The ROM is modelled as rom_bits = rom_addr ^ 8'h86.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

`ifdef SPRITE_ROM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic        frame_sync;
    logic [1:0]  req;
    logic [15:0] req_addr;
    logic [1:0]  gnt;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_bits;
    logic [7:0]  rd_data;
    logic [1:0]  rd_valid;
    logic [15:0] stall_count;

    logic        frame_sync4;
    logic [3:0]  req4;
    logic [31:0] req_addr4;
    logic [3:0]  gnt4;
    logic [7:0]  rom_addr4;
    logic [7:0]  rom_bits4;
    logic [7:0]  rd_data4;
    logic [3:0]  rd_valid4;
    logic [15:0] stall_count4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign rom_bits  = rom_addr ^ 8'h86;
    assign rom_bits4 = rom_addr4 ^ 8'h86;

    sprite_rom_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_sync  (frame_sync),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_addr    (rom_addr),
        .rom_bits    (rom_bits),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .stall_count (stall_count)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .frame_sync  (frame_sync4),
        .req         (req4),
        .req_addr    (req_addr4),
        .gnt         (gnt4),
        .rom_addr    (rom_addr4),
        .rom_bits    (rom_bits4),
        .rd_data     (rd_data4),
        .rd_valid    (rd_valid4),
        .stall_count (stall_count4)
    );

    // One comparison: counts it, and on a difference counts the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the two-requester instance's request and frame_sync inputs.
    task automatic applyStimulus(input logic [1:0] r, input logic fs);
        req        = r;
        frame_sync = fs;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        applyStimulus(2'b00, 1'b0);
        req_addr    = 16'h0000;
        req4        = 4'b0000;
        req_addr4   = {8'h33, 8'h22, 8'h11, 8'h00};
        frame_sync4 = 1'b0;

        // Reset state
        step();
        checkOutput("rst_gnt",      32'(gnt),         32'h0);
        checkOutput("rst_rom_addr", 32'(rom_addr),    32'h0);
        checkOutput("rst_rd_data",  32'(rd_data),     32'h0);
        checkOutput("rst_rd_valid", 32'(rd_valid),    32'h0);
        checkOutput("rst_stall",    32'(stall_count), 32'h0);
        step();
        #3 reset = 1'b0;

        // Single request: addr 23 -> data A5 two cycles later
        req_addr = {8'h41, 8'h23};
        applyStimulus(2'b01, 1'b0);
        step();
        checkOutput("single_gnt",      32'(gnt),      32'h1);
        checkOutput("single_rom_addr", 32'(rom_addr), 32'h23);
        checkOutput("single_valid_t1", 32'(rd_valid), 32'h0);
        applyStimulus(2'b00, 1'b0);
        step();
        checkOutput("single_gnt_off",  32'(gnt),      32'h0);
        checkOutput("single_valid",    32'(rd_valid), 32'h1);
        checkOutput("single_data",     32'(rd_data),  32'hA5);
        checkOutput("single_addr_hold",32'(rom_addr), 32'h23);

        // Idle frame_sync puts the pointer back on requester 0
        applyStimulus(2'b00, 1'b1);
        step();
        checkOutput("idle_fs_gnt", 32'(gnt), 32'h0);

        // Contention: alternate 0,1,0,1
        req_addr = {8'h41, 8'h00};
        applyStimulus(2'b11, 1'b0);
        step();
        checkOutput("cont1_gnt",   32'(gnt),         32'h1);
        checkOutput("cont1_addr",  32'(rom_addr),    32'h00);
        checkOutput("cont1_stall", 32'(stall_count), STATS ? 32'd1 : 32'd0);
        step();
        checkOutput("cont2_gnt",   32'(gnt),      32'h2);
        checkOutput("cont2_addr",  32'(rom_addr), 32'h41);
        checkOutput("cont2_valid", 32'(rd_valid), 32'h1);
        checkOutput("cont2_data",  32'(rd_data),  32'h86);
        step();
        checkOutput("cont3_gnt",   32'(gnt),      32'h1);
        checkOutput("cont3_addr",  32'(rom_addr), 32'h00);
        checkOutput("cont3_valid", 32'(rd_valid), 32'h2);
        checkOutput("cont3_data",  32'(rd_data),  32'hC7);
        step();
        checkOutput("cont4_gnt",   32'(gnt),      32'h2);
        checkOutput("cont4_valid", 32'(rd_valid), 32'h1);
        step();
        checkOutput("cont5_gnt",   32'(gnt),         32'h1);
        checkOutput("cont5_stall", 32'(stall_count), STATS ? 32'd1 : 32'd0);

        // Drain with pointer left at 1
        applyStimulus(2'b00, 1'b0);
        step();
        checkOutput("drain_gnt",   32'(gnt),      32'h0);
        checkOutput("drain_valid", 32'(rd_valid), 32'h1);
        checkOutput("drain_data",  32'(rd_data),  32'h86);

        // frame_sync cycle still arbitrates with the old pointer (1) and
        // its counter clear wins over that cycle's contention
        applyStimulus(2'b11, 1'b1);
        step();
        checkOutput("fs_oldptr_gnt",  32'(gnt),         32'h2);
        checkOutput("fs_oldptr_addr", 32'(rom_addr),    32'h41);
        checkOutput("fs_stall_clear", 32'(stall_count), 32'h0);
        applyStimulus(2'b00, 1'b0);
        step();
        checkOutput("fs_gnt_off", 32'(gnt),      32'h0);
        checkOutput("fs_valid",   32'(rd_valid), 32'h2);
        checkOutput("fs_data",    32'(rd_data),  32'hC7);

        // Grant to 0 would move the pointer to 1; frame_sync holds it at 0
        applyStimulus(2'b01, 1'b1);
        step();
        checkOutput("fs_override_gnt", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 1'b0);
        step();
        checkOutput("fs_override_idle", 32'(gnt), 32'h0);
        applyStimulus(2'b11, 1'b0);
        step();
        checkOutput("fs_override_next", 32'(gnt),         32'h1);
        checkOutput("fs_override_stall",32'(stall_count), STATS ? 32'd1 : 32'd0);

        // Requester 1 lost the previous cycle and now withdraws
        applyStimulus(2'b00, 1'b0);
        step();
        checkOutput("withdraw_gnt1",   32'(gnt),      32'h0);
        checkOutput("withdraw_valid1", 32'(rd_valid), 32'h1);
        step();
        checkOutput("withdraw_gnt2",   32'(gnt),      32'h0);
        checkOutput("withdraw_valid2", 32'(rd_valid), 32'h0);

        // Asynchronous reset while requester 1 holds the grant
        applyStimulus(2'b10, 1'b0);
        step();
        checkOutput("pre_rst_gnt",  32'(gnt),      32'h2);
        checkOutput("pre_rst_addr", 32'(rom_addr), 32'h41);
        checkOutput("pre_rst_data", 32'(rd_data),  32'h86);
        applyStimulus(2'b00, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_gnt",   32'(gnt),         32'h0);
        checkOutput("async_rst_valid", 32'(rd_valid),    32'h0);
        checkOutput("async_rst_addr",  32'(rom_addr),    32'h0);
        checkOutput("async_rst_data",  32'(rd_data),     32'h0);
        checkOutput("async_rst_stall", 32'(stall_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(2'b11, 1'b0);
        step();
        checkOutput("post_rst_gnt", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 1'b0);
        step();

        // Four-way rotation on the wider instance
        req4 = 4'b1111;
        step();
        checkOutput("rr4_gnt1",   32'(gnt4),         32'h1);
        checkOutput("rr4_addr1",  32'(rom_addr4),    32'h00);
        checkOutput("rr4_stall1", 32'(stall_count4), STATS ? 32'd1 : 32'd0);
        step();
        checkOutput("rr4_gnt2",   32'(gnt4),      32'h2);
        checkOutput("rr4_addr2",  32'(rom_addr4), 32'h11);
        checkOutput("rr4_valid2", 32'(rd_valid4), 32'h1);
        checkOutput("rr4_data2",  32'(rd_data4),  32'h86);
        step();
        checkOutput("rr4_gnt3",   32'(gnt4),      32'h4);
        checkOutput("rr4_addr3",  32'(rom_addr4), 32'h22);
        checkOutput("rr4_data3",  32'(rd_data4),  32'h97);
        step();
        checkOutput("rr4_gnt4",   32'(gnt4),      32'h8);
        checkOutput("rr4_addr4",  32'(rom_addr4), 32'h33);
        checkOutput("rr4_data4",  32'(rd_data4),  32'hA4);
        step();
        checkOutput("rr4_gnt5",   32'(gnt4),         32'h1);
        checkOutput("rr4_stall5", 32'(stall_count4), STATS ? 32'd5 : 32'd0);

        // Every cycle has three eligible requesters: drive past saturation
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("sat_stall", 32'(stall_count4), STATS ? 32'hFFFF : 32'h0);
        step();
        step();
        step();
        checkOutput("sat_hold", 32'(stall_count4), STATS ? 32'hFFFF : 32'h0);
        frame_sync4 = 1'b1;
        step();
        checkOutput("sat_fs_clear", 32'(stall_count4), 32'h0);
        frame_sync4 = 1'b0;
        req4        = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
